// File: rtl/parity_checker_rx_pkg.sv
// parity_pkg: shared types and constants for the parity-checking serial receiver.
//   rx_state_e      receiver FSM states
//   GOOD/BAD/BLANK  default seven-segment patterns (active-low segments)
//   AN_SEL          anode pattern selecting the single lit digit
//   FRAME_BITS      serial bits per frame for the default word width
//                   (start + data + parity + stop)
package parity_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  localparam logic [7:0] GOOD_SEG  = 8'b00000011;
  localparam logic [7:0] BAD_SEG   = 8'b01100001;
  localparam logic [7:0] BLANK_SEG = 8'b11111111;
  localparam logic [3:0] AN_SEL    = 4'b1101;

  localparam int N_SW_DEF   = 8;
  localparam int FRAME_BITS = N_SW_DEF + 3;

endpackage

// File: rtl/parity_checker_rx_bit_sync.sv
// bit_sync: two-flop synchroniser for a single asynchronous input.
//   i_clk    destination clock
//   i_rst_n  asynchronous active-low reset; both flops reset to RST_VAL
//   i_d      asynchronous input
//   o_q      synchronised output, two i_clk edges after i_d settles
module bit_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/parity_checker_rx.sv
// parity_checker_rx: UART-style receiver for N_SW-bit words carrying one even
// parity bit. Frame: start(0), data LSB first, parity, stop(1).
//   clk_i         system clock, rising edge
//   rst_ni        asynchronous active-low reset
//   rx_i          serial line, idle high, asynchronous to clk_i
//   data_o        last received word
//   valid_o       one-cycle pulse when a frame completes
//   parity_err_o  last frame failed parity (held until next frame)
//   frame_err_o   last frame had a low stop bit (held until next frame)
//   led_o         segment drive: BLANK after reset, then GOOD or BAD
//   led_an_o      constant anode select
module parity_checker_rx
  import parity_pkg::*;
#(
  parameter int                N_SW         = 8,
  parameter int                N_LED        = 8,
  parameter int                N_LED_AN     = 4,
  parameter int                CLKS_PER_BIT = 16,
  parameter logic [N_LED-1:0]  GOOD         = N_LED'(GOOD_SEG),
  parameter logic [N_LED-1:0]  BAD          = N_LED'(BAD_SEG),
  parameter logic [N_LED-1:0]  BLANK        = N_LED'(BLANK_SEG)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                rx_i,
  output logic [N_SW-1:0]     data_o,
  output logic                valid_o,
  output logic                parity_err_o,
  output logic                frame_err_o,
  output logic [N_LED-1:0]    led_o,
  output logic [N_LED_AN-1:0] led_an_o
);

  localparam int BIT_W  = $clog2(N_SW + 1);
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(N_SW - 1);

  logic              w_rx_s;
  logic              w_fall;
  logic              w_baud_end;
  logic              w_perr;
  logic              w_ferr;

  rx_state_e         r_state;
  logic [BAUD_W-1:0] r_baud;
  logic [BIT_W-1:0]  r_bits;
  logic              r_rx_d;
  logic              r_done;
  logic [N_SW-1:0]   r_shift;
  logic              r_par;
  logic              r_stop;

  bit_sync #(
    .RST_VAL (1'b1)
  ) u_sync (
    .i_clk   (clk_i),
    .i_rst_n (rst_ni),
    .i_d     (rx_i),
    .o_q     (w_rx_s)
  );

  // Start only on a 1->0 edge of the synchronised line, so a line stuck low
  // after a framing error cannot retrigger the receiver.
  assign w_fall     = r_rx_d & ~w_rx_s;
  assign w_baud_end = (r_baud == BAUD_LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bits  <= '0;
      r_rx_d  <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_rx_d <= w_rx_s;
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_fall) begin
            r_state <= START;
            r_baud  <= '0;
          end
        end
        // Half-bit wait lands later samples mid-bit; a high line here is a glitch.
        START: begin
          if (r_baud == HALF_LAST) begin
            r_baud  <= '0;
            r_bits  <= '0;
            r_state <= w_rx_s ? IDLE : DATA;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        DATA: begin
          if (w_baud_end) begin
            r_baud <= '0;
            r_bits <= r_bits + 1'b1;
            if (r_bits == BIT_LAST) r_state <= PARITY;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        PARITY: begin
          if (w_baud_end) begin
            r_baud  <= '0;
            r_state <= STOP;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        // Leave mid-stop-bit so the next start edge can follow immediately.
        STOP: begin
          if (w_baud_end) begin
            r_baud  <= '0;
            r_done  <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Sample registers hold datapath only; they are qualified by FSM state.
  always_ff @(posedge clk_i) begin
    if (r_state == DATA && w_baud_end) r_shift <= {w_rx_s, r_shift[N_SW-1:1]};
    if (r_state == PARITY && w_baud_end) r_par <= w_rx_s;
    if (r_state == STOP && w_baud_end) r_stop <= w_rx_s;
  end

  assign w_perr = ^{r_shift, r_par};
  assign w_ferr = ~r_stop;

  // Output register: status updates only alongside the valid pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_o      <= 1'b0;
      data_o       <= '0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
      led_o        <= BLANK;
    end else begin
      valid_o <= r_done;
      if (r_done) begin
        data_o       <= r_shift;
        parity_err_o <= w_perr;
        frame_err_o  <= w_ferr;
        led_o        <= (w_perr || w_ferr) ? BAD : GOOD;
      end
    end
  end

  assign led_an_o = N_LED_AN'(AN_SEL);

endmodule

// File: tb/tb_parity_checker_rx.sv
module tb_parity_checker_rx;
  import parity_pkg::*;

  localparam int CPB = 4;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       rx_i = 1'b1;
  logic [7:0] data_o;
  logic       valid_o;
  logic       parity_err_o;
  logic       frame_err_o;
  logic [7:0] led_o;
  logic [3:0] led_an_o;

  parity_checker_rx #(
    .N_SW         (8),
    .N_LED        (8),
    .N_LED_AN     (4),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .rx_i         (rx_i),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .parity_err_o (parity_err_o),
    .frame_err_o  (frame_err_o),
    .led_o        (led_o),
    .led_an_o     (led_an_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad = 0;

  int         cyc = 0;
  int         v_cyc[$];
  logic [7:0] v_data[$];
  logic       v_perr[$];
  logic       v_ferr[$];
  int         unstable = 0;
  logic [17:0] prev_st = '0;
  logic       prev_rst = 1'b0;

  // Monitor: logs every valid cycle and flags status changes outside valid.
  always @(posedge clk_i) begin
    cyc = cyc + 1;
    #1;
    if (valid_o === 1'b1) begin
      v_cyc.push_back(cyc);
      v_data.push_back(data_o);
      v_perr.push_back(parity_err_o);
      v_ferr.push_back(frame_err_o);
    end
    if (rst_ni && prev_rst && valid_o !== 1'b1 &&
        {data_o, parity_err_o, frame_err_o, led_o} !== prev_st)
      unstable = unstable + 1;
    prev_st  = {data_o, parity_err_o, frame_err_o, led_o};
    prev_rst = rst_ni;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the last stop-bit cycle.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                            output int t0);
    rx_i = 1'b0;
    t0 = cyc + 1;
    repeat (CPB) @(negedge clk_i);
    for (int i = 0; i < 8; i++) begin
      rx_i = d[i];
      repeat (CPB) @(negedge clk_i);
    end
    rx_i = p;
    repeat (CPB) @(negedge clk_i);
    rx_i = s;
    repeat (CPB) @(negedge clk_i);
  endtask

  int t0, t1, nv;

  initial begin
    // Reset state
    rst_ni = 1'b0;
    rx_i   = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_data", 32'(data_o), 32'h00);
    chk("rst_perr", 32'(parity_err_o), 32'd0);
    chk("rst_ferr", 32'(frame_err_o), 32'd0);
    chk("rst_led", 32'(led_o), 32'hFF);
    chk("rst_an", 32'(led_an_o), 32'hD);
    rst_ni = 1'b1;
    repeat (5) @(negedge clk_i);
    chk("post_rst_state", 32'(dut.r_state), 32'(IDLE));
    chk("post_rst_led", 32'(led_o), 32'hFF);
    chk("post_rst_nvalid", 32'(v_cyc.size()), 32'd0);

    // Clean frame A5
    nv = v_cyc.size();
    send_frame(8'hA5, 1'b0, 1'b1, t0);
    repeat (6) @(negedge clk_i);
    chk("a5_count", 32'(v_cyc.size() - nv), 32'd1);
    chk("a5_latency", 32'(v_cyc[$] - t0), 32'd45);
    chk("a5_data", 32'(data_o), 32'hA5);
    chk("a5_perr", 32'(parity_err_o), 32'd0);
    chk("a5_ferr", 32'(frame_err_o), 32'd0);
    chk("a5_led", 32'(led_o), 32'h03);
    chk("a5_valid_low", 32'(valid_o), 32'd0);

    // Parity error: 01 with parity 0
    nv = v_cyc.size();
    send_frame(8'h01, 1'b0, 1'b1, t0);
    repeat (6) @(negedge clk_i);
    chk("p01_count", 32'(v_cyc.size() - nv), 32'd1);
    chk("p01_data", 32'(data_o), 32'h01);
    chk("p01_perr", 32'(parity_err_o), 32'd1);
    chk("p01_ferr", 32'(frame_err_o), 32'd0);
    chk("p01_led", 32'(led_o), 32'h61);

    // Framing error: 3C, stop low, line kept low afterwards
    nv = v_cyc.size();
    send_frame(8'h3C, 1'b0, 1'b0, t0);
    repeat (60) @(negedge clk_i);
    chk("f3c_count", 32'(v_cyc.size() - nv), 32'd1);
    chk("f3c_data", 32'(data_o), 32'h3C);
    chk("f3c_perr", 32'(parity_err_o), 32'd0);
    chk("f3c_ferr", 32'(frame_err_o), 32'd1);
    chk("f3c_led", 32'(led_o), 32'h61);
    rx_i = 1'b1;
    repeat (8) @(negedge clk_i);
    nv = v_cyc.size();
    send_frame(8'h5A, 1'b0, 1'b1, t0);
    repeat (6) @(negedge clk_i);
    chk("after_f_count", 32'(v_cyc.size() - nv), 32'd1);
    chk("after_f_data", 32'(data_o), 32'h5A);
    chk("after_f_ferr", 32'(frame_err_o), 32'd0);
    chk("after_f_led", 32'(led_o), 32'h03);

    // One-cycle glitch
    nv = v_cyc.size();
    rx_i = 1'b0;
    @(negedge clk_i);
    rx_i = 1'b1;
    repeat (50) @(negedge clk_i);
    chk("glitch_count", 32'(v_cyc.size() - nv), 32'd0);
    chk("glitch_state", 32'(dut.r_state), 32'(IDLE));
    chk("glitch_data", 32'(data_o), 32'h5A);

    // Reset during data bits, then back-to-back clean frames
    nv = v_cyc.size();
    rx_i = 1'b0;
    repeat (CPB) @(negedge clk_i);
    rx_i = 1'b1;
    repeat (CPB) @(negedge clk_i);
    rx_i = 1'b0;
    repeat (CPB) @(negedge clk_i);
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("midrst_data", 32'(data_o), 32'h00);
    chk("midrst_led", 32'(led_o), 32'hFF);
    rst_ni = 1'b1;
    rx_i   = 1'b1;
    repeat (10) @(negedge clk_i);
    chk("midrst_count", 32'(v_cyc.size() - nv), 32'd0);
    send_frame(8'hFF, 1'b0, 1'b1, t0);
    send_frame(8'h00, 1'b0, 1'b1, t1);
    repeat (6) @(negedge clk_i);
    chk("b2b_count", 32'(v_cyc.size() - nv), 32'd2);
    chk("b2b_latency", 32'(v_cyc[nv] - t0), 32'd45);
    chk("b2b_gap", 32'(v_cyc[nv+1] - v_cyc[nv]), 32'(FRAME_BITS * CPB));
    chk("b2b_data0", 32'(v_data[nv]), 32'hFF);
    chk("b2b_perr0", 32'(v_perr[nv]), 32'd0);
    chk("b2b_ferr0", 32'(v_ferr[nv]), 32'd0);
    chk("b2b_data1", 32'(v_data[nv+1]), 32'h00);
    chk("b2b_perr1", 32'(v_perr[nv+1]), 32'd0);
    chk("b2b_led", 32'(led_o), 32'h03);

    chk("status_stable", 32'(unstable), 32'd0);
    chk("an_const", 32'(led_an_o), 32'hD);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
